// File: rtl/bist_uart_pkg.sv
// bist_uart_pkg: shared state type, ASCII constants and frame geometry for
// the BIST UART reporter. Build macro BIST_UART_CRLF_EN selects the 6-byte
// "XXXX\r\n" frame; without it the frame is 5 bytes "XXXX ".
package bist_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] SP = 8'h20;

`ifdef BIST_UART_CRLF_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif

  localparam logic [2:0] LAST_BYTE_IDX = 3'(FRAME_LEN - 1);

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex2ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) return 8'h30 + {4'h0, nibble};
    else                return 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer for one byte at a time. Chains bytes with no
// idle gap when the parent says more bytes follow.
//
// Handshake: start_i is a one-cycle pulse accepted only in IDLE; it begins
// a start bit on the next cycle. data_i is sampled at the end of the start
// bit, so the parent may update it up to then. done_o is a one-cycle pulse
// in the last cycle of the stop bit. If more_i is high in that cycle the
// next start bit follows immediately; otherwise the serializer returns to
// IDLE and busy_o drops on the same edge.
module uart_tx_byte
  import bist_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       more_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] state_o
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_t state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;
  logic        tx_q;
  logic        busy_q;
  logic        bit_end;

  assign bit_end = (cnt_q == BIT_LAST);
  assign done_o  = (state_q == STOP) && bit_end;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;
  assign state_o = state_q;

  // Bit-timing counter plus START/DATA/STOP sequencing with registered tx/busy.
  // The shift register backfills with 1s so the ninth shift yields the stop level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '1;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      cnt_q <= (state_q == IDLE || bit_end) ? 16'd0 : cnt_q + 16'd1;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            tx_q      <= data_i[0];
            shreg_q   <= {1'b1, data_i[7:1]};
            bit_idx_q <= 3'd0;
          end
        end
        DATA: begin
          if (bit_end) begin
            tx_q      <= shreg_q[0];
            shreg_q   <= {1'b1, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (more_i) begin
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bist_uart_report.sv
// bist_uart_report: watches the BIST result word and sends each new value as
// four ASCII hex digits plus a terminator over an 8N1 UART line.
// Build macro BIST_UART_CRLF_EN: terminator CR LF (6 bytes) when defined,
// a single space (5 bytes) otherwise.
module bist_uart_report
  import bist_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  frame_cnt,
  output logic [1:0]  dbg_state_o
);

  logic        primed_q;
  logic        active_q;
  logic        start_q;
  logic [15:0] snapshot_q;
  logic [15:0] last_sent_q;
  logic [2:0]  byte_idx_q;
  logic [7:0]  frame_cnt_q;
  logic [7:0]  tx_byte;
  logic        last_byte;
  logic        tx_done;

  assign last_byte = (byte_idx_q == LAST_BYTE_IDX);
  assign frame_cnt = frame_cnt_q;

  // Byte currently being framed, chosen from the frozen snapshot.
  always_comb begin
    tx_byte = SP;
    case (byte_idx_q)
      3'd0: tx_byte = hex2ascii(snapshot_q[15:12]);
      3'd1: tx_byte = hex2ascii(snapshot_q[11:8]);
      3'd2: tx_byte = hex2ascii(snapshot_q[7:4]);
      3'd3: tx_byte = hex2ascii(snapshot_q[3:0]);
`ifdef BIST_UART_CRLF_EN
      3'd4: tx_byte = CR;
      3'd5: tx_byte = LF;
`else
      3'd4: tx_byte = SP;
`endif
      default: tx_byte = SP;
    endcase
  end

  // Change detection, snapshot, byte index and completed-frame counter.
  // Only the value present in an idle cycle is compared, so values that
  // come and go during a frame are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      primed_q    <= 1'b1;
      active_q    <= 1'b0;
      start_q     <= 1'b0;
      snapshot_q  <= '0;
      last_sent_q <= '0;
      byte_idx_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      start_q <= 1'b0;
      if (!active_q) begin
        if (primed_q || (value != last_sent_q)) begin
          snapshot_q  <= value;
          last_sent_q <= value;
          primed_q    <= 1'b0;
          byte_idx_q  <= 3'd0;
          active_q    <= 1'b1;
          start_q     <= 1'b1;
        end
      end else if (tx_done) begin
        if (last_byte) begin
          active_q    <= 1'b0;
          frame_cnt_q <= frame_cnt_q + 8'd1;
        end else begin
          byte_idx_q <= byte_idx_q + 3'd1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .start_i(start_q),
    .more_i (!last_byte),
    .data_i (tx_byte),
    .tx_o   (tx),
    .busy_o (busy),
    .done_o (tx_done),
    .state_o(dbg_state_o)
  );

endmodule

// File: tb/tb_bist_uart_report.sv
// Bench for bist_uart_report with CLKS_PER_BIT=4. Frame tail and length
// follow BIST_UART_CRLF_EN the same way the design does.
module tb_bist_uart_report;

  localparam int CPB = 4;
`ifdef BIST_UART_CRLF_EN
  localparam int FL = 6;
`else
  localparam int FL = 5;
`endif
  localparam int FRAME_CYC = FL * 10 * CPB;

  typedef struct {
    logic [15:0] value;
    logic [31:0] hex;   // expected ASCII digits, first-sent byte in [31:24]
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        tx;
  logic        busy;
  logic [7:0]  frame_cnt;
  logic [1:0]  dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  logic busy_d = 1'b0;
  int rise_cyc = 0;
  int fall_cyc = 0;

  logic [7:0] exp_q[$];
  vec_t vecs[5];

  bist_uart_report #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .tx         (tx),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // busy edge timestamps, sampled on the inactive edge
  always @(negedge clk) begin
    busy_d <= busy;
    if (busy === 1'b1 && busy_d === 1'b0) rise_cyc <= cyc;
    if (busy === 1'b0 && busy_d === 1'b1) fall_cyc <= cyc;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vec_cnt++;
    if (act !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0h required %0h", name, act, exp_v);
    end
  endtask

  task automatic set_value(input logic [15:0] v);
    @(posedge clk);
    #1 value = v;
  endtask

  task automatic push_hex(input logic [31:0] hex);
    for (int j = 3; j >= 0; j--) exp_q.push_back(hex[j*8 +: 8]);
`ifdef BIST_UART_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(8'h20);
`endif
  endtask

  // UART receiver: samples bit centres on negedges, checks framing and
  // back-to-back bytes, and scores each byte against exp_q.
  task automatic rx_frame(input string tag);
    logic [7:0] b;
    int t;
    b = 8'h00;
    t = 0;
    @(negedge clk);
    while (tx !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, " start seen"}, {31'd0, tx}, 32'd0);
    if (tx !== 1'b0) begin
      exp_q.delete();
      return;
    end
    for (int k = 0; k < FL; k++) begin
      if (k > 0) check($sformatf("%s byte%0d gapless", tag, k), {31'd0, tx}, 32'd0);
      repeat (2) @(negedge clk);
      check($sformatf("%s byte%0d start bit", tag, k), {31'd0, tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        b[i] = tx;
      end
      repeat (4) @(negedge clk);
      check($sformatf("%s byte%0d stop bit", tag, k), {31'd0, tx}, 32'd1);
      repeat (2) @(negedge clk);
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s byte%0d: got %0h required nothing (no byte expected)", tag, k, b);
      end else begin
        check($sformatf("%s byte%0d data", tag, k), {24'd0, b}, {24'd0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic frame_post(input string tag, input logic [7:0] exp_fc);
    @(posedge clk);
    #1;
    check({tag, " busy length"}, fall_cyc - rise_cyc, FRAME_CYC);
    check({tag, " frame_cnt"}, {24'd0, frame_cnt}, {24'd0, exp_fc});
    check({tag, " queue drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check({tag, " idle cycles disturbed"}, bad, 32'd0);
  endtask

  task automatic wait_frame(input string tag);
    int t;
    t = 0;
    while (busy !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, " busy rise"}, {31'd0, busy}, 32'd1);
    t = 0;
    while (busy !== 1'b0 && t < FRAME_CYC + 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, " busy fall"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'hBEEF, 32'h42454546};
    vecs[1] = '{16'h09AF, 32'h30394146};
    vecs[2] = '{16'hFFFF, 32'h46464646};
    vecs[3] = '{16'h7E5D, 32'h37453544};
    vecs[4] = '{16'h0000, 32'h30303030};

    // reset state, then the primed send of 0x0000 and silence afterwards
    repeat (4) @(posedge clk);
    #1;
    check("reset tx", {31'd0, tx}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset frame_cnt", {24'd0, frame_cnt}, 32'd0);
    check("reset state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    push_hex(32'h30303030);
    rx_frame("primed");
    frame_post("primed", 8'd1);
    idle_check("steady", 1000);

    // exact one-cycle latency from the latching edge to the start bit
    set_value(16'h1A2F);
    @(posedge clk);
    #1;
    check("latency tx at latch edge", {31'd0, tx}, 32'd1);
    check("latency busy at latch edge", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("latency tx one edge later", {31'd0, tx}, 32'd0);
    check("latency busy one edge later", {31'd0, busy}, 32'd1);
    push_hex(32'h31413246);
    rx_frame("1A2F");
    frame_post("1A2F", 8'd2);

    // table of values with hand-computed digit bytes
    for (int i = 0; i < 5; i++) begin
      set_value(vecs[i].value);
      push_hex(vecs[i].hex);
      rx_frame($sformatf("vec%0d", i));
      frame_post($sformatf("vec%0d", i), 8'(3 + i));
    end

    // value changes mid-frame: 5678 is dropped, 9ABC follows 1234
    set_value(16'h1234);
    push_hex(32'h31323334);
    fork
      rx_frame("mid 1234");
      begin
        repeat (50) @(posedge clk);
        #1 value = 16'h5678;
        repeat (50) @(posedge clk);
        #1 value = 16'h9ABC;
      end
    join
    push_hex(32'h39414243);
    rx_frame("mid 9ABC");
    frame_post("mid", 8'd9);
    idle_check("after mid", 300);

    // reset during a data bit of byte 2, then full re-send from byte 0
    set_value(16'hC0DE);
    push_hex(32'h43304445);
    repeat (2) @(posedge clk);
    repeat (95) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort tx", {31'd0, tx}, 32'd1);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort frame_cnt", {24'd0, frame_cnt}, 32'd0);
    check("abort state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    rx_frame("resend");
    frame_post("resend", 8'd1);

    // 256 frames from reset: frame_cnt wraps to zero, none lost
    @(posedge clk);
    #1;
    rst = 1'b1;
    value = 16'h0000;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_frame("wrap primed");
    @(posedge clk);
    #1;
    check("wrap primed frame_cnt", {24'd0, frame_cnt}, 32'd1);
    for (int i = 1; i < 256; i++) begin
      set_value(16'(i));
      wait_frame("wrap");
      @(posedge clk);
      #1;
      check($sformatf("wrap frame_cnt after %0d", i), {24'd0, frame_cnt}, {24'd0, 8'(i + 1)});
    end
    check("wrap final zero", {24'd0, frame_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
